// File: rtl/ccip_avmm_host_arbiter.sv
// Two-master Avalon-MM arbiter in front of a CCI-P host bridge: round-robin command
// selection, write-burst locking, and a read-tag FIFO that routes returning beats.
module ccip_avmm_host_arbiter #(
    parameter int DATA_WIDTH  = 512,
    parameter int ADDR_WIDTH  = 48,
    parameter int BURST_WIDTH = 3,
    parameter int TAG_DEPTH   = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        m0_read,
    input  logic                        m0_write,
    input  logic [ADDR_WIDTH-1:0]       m0_address,
    input  logic [BURST_WIDTH-1:0]      m0_burstcount,
    input  logic [DATA_WIDTH-1:0]       m0_writedata,
    output logic                        m0_waitrequest,
    output logic [DATA_WIDTH-1:0]       m0_readdata,
    output logic                        m0_readdatavalid,
    input  logic                        m1_read,
    input  logic                        m1_write,
    input  logic [ADDR_WIDTH-1:0]       m1_address,
    input  logic [BURST_WIDTH-1:0]      m1_burstcount,
    input  logic [DATA_WIDTH-1:0]       m1_writedata,
    output logic                        m1_waitrequest,
    output logic [DATA_WIDTH-1:0]       m1_readdata,
    output logic                        m1_readdatavalid,
    output logic                        host_read,
    output logic                        host_write,
    output logic [ADDR_WIDTH-1:0]       host_address,
    output logic [BURST_WIDTH-1:0]      host_burstcount,
    output logic [DATA_WIDTH-1:0]       host_writedata,
    input  logic                        host_waitrequest,
    input  logic                        host_readdatavalid,
    input  logic [DATA_WIDTH-1:0]       host_readdata,
    output logic [$clog2(TAG_DEPTH):0]  outstanding_reads,
    output logic                        cmd_error,
    output logic                        rsp_error
);
    localparam int TAG_AW = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {UNLOCKED, LOCK_M0, LOCK_M1} lock_t;

    lock_t                  lock_state, lock_next;
    logic [1:0]             beats_left, beats_next;
    logic                   last_served;
    logic                   sel, grant, sel_write, accept, legal_bc;
    logic [BURST_WIDTH-1:0] sel_bc;
    logic                   elig0, elig1, full, empty, push, pop;

    logic                   tag_id    [TAG_DEPTH];
    logic [2:0]             tag_beats [TAG_DEPTH];
    logic [TAG_AW-1:0]      wr_ptr, rd_ptr;
    logic [TAG_AW:0]        count;
    logic [1:0]             head_rcvd;

    assign full  = (count == (TAG_AW+1)'(TAG_DEPTH));
    assign empty = (count == '0);
    assign elig0 = m0_write | (m0_read & ~full);
    assign elig1 = m1_write | (m1_read & ~full);

    // A locked master is granted only for its write beats; its reads wait for the lock to clear.
    always_comb begin
        grant = 1'b0;
        sel   = 1'b0;
        case (lock_state)
            LOCK_M0: grant = m0_write;
            LOCK_M1: begin grant = m1_write; sel = 1'b1; end
            default: begin
                if (elig0 && elig1) begin grant = 1'b1; sel = ~last_served; end
                else if (elig0)     begin grant = 1'b1; sel = 1'b0; end
                else if (elig1)     begin grant = 1'b1; sel = 1'b1; end
            end
        endcase
    end

    assign sel_write       = sel ? m1_write : m0_write;
    assign sel_bc          = sel ? m1_burstcount : m0_burstcount;
    assign host_write      = grant & sel_write & ~reset;
    assign host_read       = grant & ~sel_write & ~reset;
    assign host_address    = sel ? m1_address : m0_address;
    assign host_burstcount = sel_bc;
    assign host_writedata  = sel ? m1_writedata : m0_writedata;
    assign m0_waitrequest  = ~(grant & ~sel) | host_waitrequest | reset;
    assign m1_waitrequest  = ~(grant & sel) | host_waitrequest | reset;
    assign accept          = (host_read | host_write) & ~host_waitrequest;
    assign legal_bc        = (sel_bc == BURST_WIDTH'(1)) || (sel_bc == BURST_WIDTH'(2)) ||
                             (sel_bc == BURST_WIDTH'(4));

    always_comb begin
        lock_next  = lock_state;
        beats_next = beats_left;
        if (accept && host_write) begin
            if (lock_state != UNLOCKED) begin
                beats_next = beats_left - 2'd1;
                if (beats_left == 2'd1) lock_next = UNLOCKED;
            end else if (sel_bc == BURST_WIDTH'(2) || sel_bc == BURST_WIDTH'(4)) begin
                lock_next  = sel ? LOCK_M1 : LOCK_M0;
                beats_next = 2'(sel_bc - BURST_WIDTH'(1));
            end
        end
    end

    assign push = accept & host_read;
    assign pop  = host_readdatavalid & ~empty &
                  (({1'b0, head_rcvd} + 3'd1) == tag_beats[rd_ptr]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_state  <= UNLOCKED;
            beats_left  <= '0;
            last_served <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            head_rcvd   <= '0;
            cmd_error   <= 1'b0;
            rsp_error   <= 1'b0;
        end else begin
            lock_state <= lock_next;
            beats_left <= beats_next;
            if (accept) last_served <= sel;
            if (accept && !legal_bc) cmd_error <= 1'b1;
            if (host_readdatavalid && empty) rsp_error <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (host_readdatavalid && !empty) head_rcvd <= pop ? 2'd0 : head_rcvd + 2'd1;
        end
    end

    // Illegal burstcounts are stored as single-beat tags.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_id[wr_ptr]    <= sel;
            tag_beats[wr_ptr] <= legal_bc ? 3'(sel_bc) : 3'd1;
        end
    end

    assign outstanding_reads = count;
    assign m0_readdata       = host_readdata;
    assign m1_readdata       = host_readdata;
    assign m0_readdatavalid  = host_readdatavalid & ~empty & ~tag_id[rd_ptr] & ~reset;
    assign m1_readdatavalid  = host_readdatavalid & ~empty & tag_id[rd_ptr] & ~reset;
endmodule

// File: doc/ccip_avmm_host_arbiter.md
CCIP_AVMM_HOST_ARBITER -- requirements
Module: ccip_avmm_host_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, data width of all ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 48, byte address width.
REQ-003 SHALL have parameter BURST_WIDTH, default 3, burstcount width.
REQ-004 SHALL have parameter TAG_DEPTH, default 64 (power of 2), read-tag FIFO depth.
REQ-005 SHALL have port clk, in, 1: clock, all logic on rising edge.
REQ-006 SHALL have port reset, in, 1: reset, asynchronous, active-high.
REQ-007 SHALL have ports mN_read / mN_write (N=0,1), in, 1: requester command strobes.
REQ-008 SHALL have port mN_address, in, ADDR_WIDTH: requester address.
REQ-009 SHALL have port mN_burstcount, in, BURST_WIDTH: requester burstcount.
REQ-010 SHALL have port mN_writedata, in, DATA_WIDTH: requester write data.
REQ-011 SHALL have port mN_waitrequest, out, 1: requester stall.
REQ-012 SHALL have port mN_readdata, out, DATA_WIDTH: requester read data.
REQ-013 SHALL have port mN_readdatavalid, out, 1: requester read beat valid.
REQ-014 SHALL have ports host_read / host_write, out, 1: command strobes to CCI-P host bridge.
REQ-015 SHALL have ports host_address / host_burstcount / host_writedata, out, ADDR/BURST/DATA_WIDTH: muxed command fields.
REQ-016 SHALL have ports host_waitrequest, host_readdatavalid (in, 1) and host_readdata (in, DATA_WIDTH): host bridge responses.
REQ-017 SHALL have port outstanding_reads, out, log2(TAG_DEPTH)+1: count of queued read tags.
REQ-018 SHALL have ports cmd_error and rsp_error, out, 1: sticky error flags.

Function
REQ-019 A command SHALL be accepted when host_read or host_write is high and host_waitrequest is low in the same cycle.
REQ-020 Eligibility: mN eligible if mN_write, or mN_read and tag FIFO not full.
REQ-021 When unlocked, exactly one eligible master SHALL be selected; if both eligible, the one not last accepted wins (round robin); last_served resets to 1, so m0 wins the first tie.
REQ-022 Host command outputs SHALL combinationally mirror the selected master; with no eligible master, host_read = host_write = 0.
REQ-023 mN_waitrequest SHALL equal NOT(mN selected) OR host_waitrequest.
REQ-024 Acceptance of a write with burstcount 2 or 4 SHALL set lock to that master with beats_left = burstcount-1.
REQ-025 While locked: only the locked master SHALL be selected; each accepted write beat decrements beats_left; lock clears on the cycle that accepts the beat taking beats_left to 0; the other master's requests stay stalled, including reads.
REQ-026 Reads while locked by the same master SHALL be stalled until lock clears (no interleaving inside a write burst).
REQ-027 Each accepted read SHALL push {id, beats} into the tag FIFO, beats = burstcount (1, 2 or 4).
REQ-028 Each host_readdatavalid beat SHALL assert readdatavalid of the head-tag id in the same cycle (combinational); host_readdata broadcast to both mN_readdata.
REQ-029 Head beat counter SHALL decrement per beat; the tag SHALL pop on its last beat; push and pop in the same cycle SHALL leave the count unchanged.
REQ-030 Read burstcount values 1, 2 and 4 are legal for reads; write burstcount values 1, 2 and 4 are legal for writes. An accepted command with any other burstcount SHALL be forwarded, treated as 1 beat, and SHALL set cmd_error.
REQ-031 host_readdatavalid with an empty tag FIFO SHALL set rsp_error, drive no mN_readdatavalid, and leave state unchanged.
REQ-032 outstanding_reads SHALL equal the tag FIFO occupancy, registered.

Reset
REQ-033 Reset SHALL clear lock, beats_left, tag FIFO, head counter, outstanding_reads, cmd_error and rsp_error, and set last_served = 1.
REQ-034 During reset all mN_waitrequest SHALL be 1; host_read, host_write and mN_readdatavalid SHALL be 0.
REQ-035 Reset mid-burst or mid-response SHALL discard all state; no beat from a pre-reset command is routed after release.

Verification
REQ-036 Both masters issue a single write every cycle, host_waitrequest = 0 -> accepted beats alternate m0, m1, m0, ...
REQ-037 m0 writes burst 4 while m1 requests a read -> m0 gets 4 consecutive accepted beats, then m1 is accepted; m1_waitrequest = 1 throughout the burst.
REQ-038 m0 reads burst 2, then m1 reads burst 1; host returns 3 beats -> m0_readdatavalid on beats 1-2, m1_readdatavalid on beat 3; outstanding_reads goes 2 -> 1 -> 0.
REQ-039 Fill the tag FIFO to TAG_DEPTH with reads -> further reads stall while writes are still accepted; one popped tag -> the next read is accepted.
REQ-040 Error injection: host_readdatavalid with no outstanding reads -> rsp_error = 1; read with burstcount 3 -> cmd_error = 1; assert reset mid-burst -> all outputs at reset values.
